dff_lane_voter: RTL and testbench
=================================

# dff_lane_voter

Downstream checker for the triple-implementation D flip-flop (SR-, JK- and T-based lanes producing `q_sr`, `q_jk`, `q_t` from a common `d`). It majority-votes the three lane outputs into a single registered `q_vote`, flags any lane that disagrees with the vote, and counts disagreements per lane. A per-lane health state machine declares a lane failed after a run of consecutive mismatches, and the block raises `fatal` when the vote can no longer be trusted.

## Interface
Parameters:
- `FAIL_THRESH`, 3: consecutive mismatching samples that move a lane to FAILED; legal range 1..15.
- `CNT_W`, 8: width of each per-lane saturating mismatch counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sample_en`  in  1  when 1, lane inputs are sampled this cycle; when 0, all state holds.
- `clr_flags`  in  1  clears lane health state (FSMs, run counters, `lane_fail`, `fatal`); mismatch counters are not cleared.
- `q_sr`  in  1  SR-based lane output.
- `q_jk`  in  1  JK-based lane output.
- `q_t`  in  1  T-based lane output.
- `q_vote`  out  1  registered majority of the three lanes.
- `mismatch`  out  1  registered; 1 if any lane differed from the majority in the last sample.
- `lane_fail`  out  3  sticky failed flags; bit0 = SR, bit1 = JK, bit2 = T.
- `mis_cnt_sr`, `mis_cnt_jk`, `mis_cnt_t`  out  CNT_W each  saturating mismatch counts.
- `fatal`  out  1  1 while two or more lanes are FAILED.

## Operation
- Majority: `maj = (q_sr&q_jk)|(q_sr&q_t)|(q_jk&q_t)`, computed combinationally from the current inputs.
- Lane mismatch: `lane_mis[i] = q_i ^ maj`. At most one lane can mismatch in a given sample.
- On a `sample_en` cycle:
  - `q_vote` <= `maj`.
  - `mismatch` <= OR of `lane_mis`.
  - Each mismatching lane's counter increments, saturating at 2^CNT_W-1 and never wrapping.
- Per-lane FSM, with states OK, SUSPECT, FAILED and a 4-bit run counter:
  - OK, mismatch: run becomes 1. The lane goes to SUSPECT, or directly to FAILED if FAIL_THRESH == 1.
  - OK, match: the lane stays in OK.
  - SUSPECT, mismatch: run increments. When run reaches FAIL_THRESH the lane goes to FAILED.
  - SUSPECT, match: the lane returns to OK and run becomes 0.
  - FAILED: absorbing state, left only on `rst` or `clr_flags`.
- `lane_fail[i]` = (state_i == FAILED), registered with the FSM.
- `fatal` = popcount(`lane_fail`) >= 2, registered.
- `fatal` does not alter `q_vote`; the vote is always the plain majority.

## Timing
- Reset values: `q_vote`=0, `mismatch`=0, `lane_fail`=3'b000, all `mis_cnt_*`=0, `fatal`=0, all FSMs in OK, all runs 0.
- Latency:
  - Inputs sampled at edge k drive `q_vote`, `mismatch` and the counters after edge k (1 cycle).
  - `lane_fail` updates on the same edge as the FSM transition.
  - `fatal` follows one edge after `lane_fail`.
- `sample_en`=0: every register holds, including the FSMs and runs. A non-sampled cycle neither breaks nor extends a run.
- `clr_flags`=1 (regardless of `sample_en`):
  - FSMs go to OK, runs go to 0, `lane_fail` goes to 0, and `fatal` clears on the following edge.
  - A mismatch in the same cycle is still counted in `mis_cnt_*` and still drives `mismatch` and `q_vote` (if `sample_en`=1), but does not start a run.
- `rst` overrides `clr_flags` and `sample_en`. Reset mid-run discards the run and all counts.
- Counter saturation is independent of FSM state; FAILED lanes keep counting.

## Structure
- Package `dff_voter_pkg` holds:
  - `lane_state_e` (OK, SUSPECT, FAILED).
  - Lane index constants `LANE_SR`=0, `LANE_JK`=1, `LANE_T`=2.
  - `NUM_LANES`=3.
- Sub-module `dff_lane_monitor` is instantiated once per lane and contains that lane's FSM, run counter and saturating counter.
  - Inputs: `clk`, `rst`, `sample_en`, `clr_flags`, `lane_mis`.
  - Outputs: `failed`, `mis_cnt`.
- The top level contains only the majority logic, the `q_vote`/`mismatch`/`fatal` registers and the three monitor instances.

## Test plan
- Reset, then 10 sampled cycles with all lanes equal and toggling 0/1 -> `q_vote` follows the inputs one cycle later, `mismatch`=0, all counts 0, `lane_fail`=000.
- Force `q_jk` inverted for 2 samples, then a match -> `mismatch` pulses for 2 cycles, `mis_cnt_jk`=2, JK returns to OK, `lane_fail`=000.
- Force `q_t` wrong for 3 consecutive samples (FAIL_THRESH=3) -> `lane_fail`=3'b100 after the 3rd sample edge, and it stays set after the inputs recover.
- T stays FAILED; then `q_sr` is wrong for 3 samples -> `lane_fail`=3'b101 and `fatal`=1 one edge later. Then pulse `clr_flags` -> `lane_fail`=000, `fatal`=0, while `mis_cnt_sr`=3 and `mis_cnt_t`=3 retain their values.
- Mismatch on SR at samples 1 and 2, `sample_en`=0 for 5 cycles, then mismatch at sample 3 -> SR is FAILED; outputs hold throughout the gap.
- CNT_W=2, hold `q_jk` wrong for 6 samples -> `mis_cnt_jk` saturates at 3 and does not wrap. Assert `rst` mid-run -> all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/dff_voter_pkg.sv
// Shared types and lane indices for the triple-lane DFF voter.
// Imported by the lane monitor and the voter top.
package dff_voter_pkg;

  localparam int NUM_LANES = 3;
  localparam int LANE_SR   = 0;
  localparam int LANE_JK   = 1;
  localparam int LANE_T    = 2;

  typedef enum logic [1:0] {
    LS_OK      = 2'd0,
    LS_SUSPECT = 2'd1,
    LS_FAILED  = 2'd2
  } lane_state_e;

endpackage

// File: rtl/dff_lane_monitor.sv
// Per-lane health tracker: OK/SUSPECT/FAILED FSM with a run counter,
// plus a saturating count of every mismatching sample.
module dff_lane_monitor
  import dff_voter_pkg::*;
#(
  parameter int FAIL_THRESH = 3,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic             clr_flags,
  input  logic             lane_mis,
  output logic             failed,
  output logic [CNT_W-1:0] mis_cnt
);

  localparam logic [3:0] THR = 4'(FAIL_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  lane_state_e state, state_n;
  logic [3:0]  run, run_n;
  logic [3:0]  run_inc;

  assign run_inc = run + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LS_OK;
      run   <= 4'd0;
    end else begin
      state <= state_n;
      run   <= run_n;
    end
  end

  always_comb begin
    state_n = state;
    run_n   = run;
    if (clr_flags) begin
      state_n = LS_OK;
      run_n   = 4'd0;
    end else if (sample_en) begin
      unique case (state)
        LS_OK: begin
          if (lane_mis) begin
            run_n   = 4'd1;
            state_n = (THR == 4'd1) ? LS_FAILED
                                    : LS_SUSPECT;
          end
        end
        LS_SUSPECT: begin
          if (lane_mis) begin
            run_n = run_inc;
            if (run_inc >= THR)
              state_n = LS_FAILED;
          end else begin
            run_n   = 4'd0;
            state_n = LS_OK;
          end
        end
        LS_FAILED: state_n = LS_FAILED;
        default: begin
          state_n = LS_OK;
          run_n   = 4'd0;
        end
      endcase
    end
  end

  // Counting is independent of health state and of clr_flags.
  always_ff @(posedge clk) begin
    if (rst)
      mis_cnt <= '0;
    else if (sample_en && lane_mis && mis_cnt != CNT_MAX)
      mis_cnt <= mis_cnt + CNT_W'(1);
  end

  assign failed = (state == LS_FAILED);

endmodule

// File: rtl/dff_lane_voter.sv
// Majority voter over SR/JK/T flip-flop lanes with per-lane
// health monitors and a fatal flag when two lanes have failed.
module dff_lane_voter
  import dff_voter_pkg::*;
#(
  parameter int FAIL_THRESH = 3,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic             clr_flags,
  input  logic             q_sr,
  input  logic             q_jk,
  input  logic             q_t,
  output logic             q_vote,
  output logic             mismatch,
  output logic [2:0]       lane_fail,
  output logic [CNT_W-1:0] mis_cnt_sr,
  output logic [CNT_W-1:0] mis_cnt_jk,
  output logic [CNT_W-1:0] mis_cnt_t,
  output logic             fatal
);

  logic [NUM_LANES-1:0] lanes;
  logic [NUM_LANES-1:0] lane_mis;
  logic [CNT_W-1:0]     cnt [NUM_LANES];
  logic                 maj;
  logic                 two_failed;

  assign lanes[LANE_SR] = q_sr;
  assign lanes[LANE_JK] = q_jk;
  assign lanes[LANE_T]  = q_t;

  assign maj = (q_sr & q_jk) | (q_sr & q_t) | (q_jk & q_t);
  assign lane_mis = lanes ^ {NUM_LANES{maj}};

  // Two-of-three failed is itself a majority of the fail bits.
  assign two_failed = (lane_fail[0] & lane_fail[1])
                    | (lane_fail[0] & lane_fail[2])
                    | (lane_fail[1] & lane_fail[2]);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_vote   <= 1'b0;
      mismatch <= 1'b0;
    end else if (sample_en) begin
      q_vote   <= maj;
      mismatch <= |lane_mis;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      fatal <= 1'b0;
    else
      fatal <= two_failed;
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_mon
    dff_lane_monitor #(
      .FAIL_THRESH (FAIL_THRESH),
      .CNT_W       (CNT_W)
    ) u_mon (
      .clk       (clk),
      .rst       (rst),
      .sample_en (sample_en),
      .clr_flags (clr_flags),
      .lane_mis  (lane_mis[i]),
      .failed    (lane_fail[i]),
      .mis_cnt   (cnt[i])
    );
  end

  assign mis_cnt_sr = cnt[LANE_SR];
  assign mis_cnt_jk = cnt[LANE_JK];
  assign mis_cnt_t  = cnt[LANE_T];

endmodule

// File: tb/tb_dff_lane_voter.sv
// Directed bench for dff_lane_voter: default instance plus a
// CNT_W=2 instance on the same stimulus for saturation checks.
module tb_dff_lane_voter;

  logic       clk = 1'b0;
  logic       rst, sample_en, clr_flags;
  logic       q_sr, q_jk, q_t;
  logic       q_vote, mismatch, fatal;
  logic [2:0] lane_fail;
  logic [7:0] cnt_sr, cnt_jk, cnt_t;
  logic       q_vote2, mismatch2, fatal2;
  logic [2:0] lane_fail2;
  logic [1:0] cnt2_sr, cnt2_jk, cnt2_t;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dff_lane_voter #(.FAIL_THRESH(3), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .sample_en(sample_en),
    .clr_flags(clr_flags), .q_sr(q_sr), .q_jk(q_jk), .q_t(q_t),
    .q_vote(q_vote), .mismatch(mismatch), .lane_fail(lane_fail),
    .mis_cnt_sr(cnt_sr), .mis_cnt_jk(cnt_jk), .mis_cnt_t(cnt_t),
    .fatal(fatal)
  );

  dff_lane_voter #(.FAIL_THRESH(3), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .sample_en(sample_en),
    .clr_flags(clr_flags), .q_sr(q_sr), .q_jk(q_jk), .q_t(q_t),
    .q_vote(q_vote2), .mismatch(mismatch2), .lane_fail(lane_fail2),
    .mis_cnt_sr(cnt2_sr), .mis_cnt_jk(cnt2_jk), .mis_cnt_t(cnt2_t),
    .fatal(fatal2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic en, input logic clr,
                      input logic sr, input logic jk, input logic t);
    rst = r; sample_en = en; clr_flags = clr;
    q_sr = sr; q_jk = jk; q_t = t;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_vote"}, q_vote, 0);
    chk({tag, "_mis"}, mismatch, 0);
    chk({tag, "_fail"}, lane_fail, 0);
    chk({tag, "_cnt"}, {cnt_sr, cnt_jk, cnt_t}, 0);
    chk({tag, "_fatal"}, fatal, 0);
    chk({tag, "_cnt2"}, {cnt2_sr, cnt2_jk, cnt2_t}, 0);
    chk({tag, "_fail2"}, lane_fail2, 0);
  endtask

  initial begin
    step(1, 0, 0, 1, 1, 1);
    step(1, 1, 1, 1, 0, 1);
    chk_reset_state("reset");

    // all lanes agree, toggling
    for (int i = 0; i < 10; i++) begin
      logic v;
      v = logic'(i % 2);
      step(0, 1, 0, v, v, v);
      chk("agree_vote", q_vote, v);
      chk("agree_mis", mismatch, 0);
    end
    chk("agree_cnt", {cnt_sr, cnt_jk, cnt_t}, 0);
    chk("agree_fail", lane_fail, 0);

    // JK wrong twice, then recovers
    step(0, 1, 0, 1, 0, 1);
    chk("jk1_mis", mismatch, 1);
    chk("jk1_vote", q_vote, 1);
    step(0, 1, 0, 1, 0, 1);
    chk("jk2_mis", mismatch, 1);
    step(0, 1, 0, 1, 1, 1);
    chk("jk3_mis", mismatch, 0);
    chk("jk_cnt", cnt_jk, 2);
    chk("jk_fail", lane_fail, 3'b000);

    // T wrong three times -> T failed
    step(0, 1, 0, 0, 0, 1);
    chk("t1_fail", lane_fail, 3'b000);
    chk("t1_vote", q_vote, 0);
    step(0, 1, 0, 0, 0, 1);
    chk("t2_fail", lane_fail, 3'b000);
    step(0, 1, 0, 0, 0, 1);
    chk("t3_fail", lane_fail, 3'b100);
    step(0, 1, 0, 0, 0, 0);
    chk("t_sticky", lane_fail, 3'b100);
    chk("t_fatal", fatal, 0);
    chk("t_cnt", cnt_t, 3);

    // SR wrong three times -> two lanes failed
    step(0, 1, 0, 0, 1, 1);
    step(0, 1, 0, 0, 1, 1);
    step(0, 1, 0, 0, 1, 1);
    chk("sr3_fail", lane_fail, 3'b101);
    chk("sr3_fatal", fatal, 0);
    step(0, 1, 0, 1, 1, 1);
    chk("sr_fatal", fatal, 1);
    chk("sr_vote", q_vote, 1);
    step(0, 0, 1, 1, 1, 1);
    chk("clr_fail", lane_fail, 3'b000);
    step(0, 0, 0, 1, 1, 1);
    chk("clr_fatal", fatal, 0);
    chk("clr_cnt_sr", cnt_sr, 3);
    chk("clr_cnt_t", cnt_t, 3);
    chk("clr_cnt_jk", cnt_jk, 2);

    // SR run across a sample_en gap
    step(0, 1, 0, 0, 1, 1);
    step(0, 1, 0, 0, 1, 1);
    chk("gap_pre_fail", lane_fail, 3'b000);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 0, 0);
      chk("gap_vote", q_vote, 1);
      chk("gap_mis", mismatch, 1);
      chk("gap_cnt", cnt_sr, 5);
      chk("gap_fail", lane_fail, 3'b000);
    end
    step(0, 1, 0, 0, 1, 1);
    chk("gap_post_fail", lane_fail, 3'b001);
    chk("gap_post_cnt", cnt_sr, 6);

    // clr with a same-cycle mismatch counts but starts no run
    step(0, 1, 1, 1, 0, 1);
    chk("clrmis_mis", mismatch, 1);
    chk("clrmis_cnt", cnt_jk, 3);
    chk("clrmis_fail", lane_fail, 3'b000);
    step(0, 1, 0, 1, 0, 1);
    step(0, 1, 0, 1, 0, 1);
    chk("clrmis_run", lane_fail, 3'b000);

    // saturation on the narrow instance, then reset mid-run
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 1, 0, 1);
      chk("sat_cnt2", cnt2_jk, (i < 3) ? i + 1 : 3);
      chk("sat_cnt", cnt_jk, i + 1);
    end
    chk("sat_fail", lane_fail, 3'b010);
    step(1, 1, 1, 1, 0, 1);
    chk_reset_state("midrst");
    step(0, 1, 0, 1, 0, 1);
    chk("post_rst_fail", lane_fail, 3'b000);
    chk("post_rst_cnt", cnt_jk, 1);
    chk("post_rst_cnt2", cnt2_jk, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
